ctrl_pipe_hazard: RTL
=====================

Name: ctrl_pipe_hazard

Overview:
- Consumer side of the decoded control bundle produced by the ID-stage control unit.
- Carries the control signals through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and multi-cycle multiply occupancy, and generates the PC/IF-ID stall and flush controls.
- Inserts bubbles (all-zero control) where required. The datapath pipeline registers use its hold/flush outputs.

Parameters:
- MULT_LAT, 3: cycles a multiply occupies EX (legal range 1 to 8).
- REG_ADDR_W, 5: register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_alu_op  in  2  decoded ALUOp.
- id_branch, id_mem_read, id_mem_2_reg, id_mem_write, id_alu_src, id_reg_write, id_jump  in  1 each  decoded controls.
- id_mult  in  1  ID instruction is a multiply.
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  ID register indices.
- ex_taken  in  1  EX resolved branch taken or jump.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID register clear.
- id_ex_hold  out  1  datapath ID/EX register hold.
- ex_alu_op  out  2  registered EX control.
- ex_alu_src, ex_branch, ex_jump, ex_mem_read, ex_mult  out  1 each  registered EX controls.
- ex_rd  out  REG_ADDR_W  registered EX destination.
- mem_mem_read, mem_mem_write, mem_mem_2_reg, mem_reg_write  out  1 each  registered MEM controls.
- mem_rd  out  REG_ADDR_W  registered MEM destination.
- wb_reg_write, wb_mem_2_reg  out  1 each  registered WB controls.
- wb_rd  out  REG_ADDR_W  registered WB destination.
- mult_busy  out  1  multiply still occupying EX.

Behaviour:
- Clock and reset:
  - Single clock clk. Reset rst is synchronous and active-high.
  - In a cycle with rst=1, every registered output, the hidden EX mem_write/mem_2_reg/reg_write fields and the multiply counter load 0 at the next edge.
  - Reset mid-multiply abandons the multiply.
- Bubble: all control bits and rd equal to 0.
- Register usage:
  - rs1_used = !id_jump.
  - rs2_used = (!id_alu_src & !id_jump) | id_mem_write.
  - Index 0 never creates a hazard.
- load_use (combinational): ex_mem_read & ex_rd!=0 & ((rs1_used & ex_rd==id_rs1) | (rs2_used & ex_rd==id_rs2)).
- Multiply counter:
  - cnt is 3 bits.
  - mult_busy = ex_mult & (cnt != MULT_LAT-1).
  - While mult_busy: cnt increments each cycle.
  - When the multiply leaves EX, cnt returns to 0.
  - MULT_LAT=1 gives no stall.
- Per-cycle priority, evaluated combinationally, updates at the clock edge:
  1. mult_busy:
     - pc_write=0, if_id_write=0, id_ex_hold=1.
     - ID/EX holds. EX/MEM loads a bubble. MEM/WB advances normally.
     - ex_taken is ignored; a multiply is never a branch.
  2. ex_taken:
     - if_id_flush=1, pc_write=1.
     - ID/EX loads a bubble, so the wrong-path ID instruction is killed.
     - EX/MEM advances normally.
  3. load_use:
     - pc_write=0, if_id_write=0.
     - ID/EX loads a bubble. EX/MEM and MEM/WB advance.
     - Exactly one stall cycle per hazard.
  4. Otherwise:
     - pc_write=1, if_id_write=1, if_id_flush=0, id_ex_hold=0.
     - All stages advance.
- Control bundle movement:
  - ID to EX: all id_* controls, id_rd and id_mult.
  - EX to MEM: mem_read, mem_write, mem_2_reg, reg_write and rd. ID/EX stores mem_write, mem_2_reg and reg_write internally, with no EX ports.
  - MEM to WB: reg_write, mem_2_reg and rd.
- Stall and flush outputs are purely combinational from the current register state and ID inputs. Latency ID to WB is 3 edges when there is no stall.
- During rst=1 the combinational outputs still follow the rules above. Their values are don't-care for the bench until the first cycle after reset.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, two extra output ports are present:
  - stall_cycles: 32-bit, increments each cycle where pc_write=0.
  - flush_count: 32-bit, increments each cycle where if_id_flush=1.
  - Both clear on rst and wrap modulo 2^32.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles with non-zero id_* inputs -> after release all ex_/mem_/wb_ outputs 0, mult_busy=0, cnt=0.
- Load-use: EX holds lw with rd=5, ID add with rs1=5 -> one cycle with pc_write=0 and if_id_write=0, then ex_* all 0 (bubble), then the add reaches EX.
- Load-use on x0, and a jump with rs1=5 -> no stall.
- Multiply with MULT_LAT=3: ID mult rd=7 -> mult_busy high for 2 cycles after it enters EX, pc_write=0 for those 2 cycles, mem_rd=7 and mem_reg_write=1 on the 3rd edge after EX entry, with 2 bubbles in MEM before it.
- Taken branch: ex_taken=1 with ex_branch=1 -> if_id_flush=1 and next ex_* all 0. ex_taken asserted concurrently with load_use in ID -> flush wins and pc_write=1.
- Reset mid-multiply: rst asserted at cnt=1 -> next cycle mult_busy=0 and all registered outputs 0. With HAZARD_STATS_EN, stall_cycles counts exactly 2 per MULT_LAT=3 multiply.

Source files
------------

// File: rtl/ctrl_pipe_hazard.sv
// Control-bundle pipeline (ID/EX, EX/MEM, MEM/WB) with load-use and multiply-occupancy hazard control.
// Optional HAZARD_STATS_EN adds stall_cycles / flush_count event counters.
module ctrl_pipe_hazard #(
    parameter int MULT_LAT   = 3,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_branch,
    input  logic                  id_mem_read,
    input  logic                  id_mem_2_reg,
    input  logic                  id_mem_write,
    input  logic                  id_alu_src,
    input  logic                  id_reg_write,
    input  logic                  id_jump,
    input  logic                  id_mult,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_taken,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_hold,
    output logic [1:0]            ex_alu_op,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic                  ex_mem_read,
    output logic                  ex_mult,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_mem_2_reg,
    output logic                  mem_reg_write,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_reg_write,
    output logic                  wb_mem_2_reg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  mult_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count
`endif
);

    localparam logic [2:0] CNT_LAST = 3'(MULT_LAT - 1);

    // EX-stage fields that travel on to MEM but have no EX port
    logic       ex_mem_write;
    logic       ex_mem_2_reg;
    logic       ex_reg_write;
    logic [2:0] cnt;

    logic rs1_used;
    logic rs2_used;
    logic load_use;
    logic id_ex_bubble;
    logic ex_mem_bubble;

    assign rs1_used  = !id_jump;
    assign rs2_used  = (!id_alu_src && !id_jump) || id_mem_write;
    assign load_use  = ex_mem_read && (ex_rd != '0) &&
                       ((rs1_used && (ex_rd == id_rs1)) || (rs2_used && (ex_rd == id_rs2)));
    assign mult_busy = ex_mult && (cnt != CNT_LAST);

    // Multiply occupancy outranks a taken branch, which outranks a load-use stall
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_hold    = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        if (mult_busy) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_hold    = 1'b1;
            ex_mem_bubble = 1'b1;
        end else if (ex_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_alu_op     <= '0;
            ex_alu_src    <= 1'b0;
            ex_branch     <= 1'b0;
            ex_jump       <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mult       <= 1'b0;
            ex_rd         <= '0;
            ex_mem_write  <= 1'b0;
            ex_mem_2_reg  <= 1'b0;
            ex_reg_write  <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_mem_write <= 1'b0;
            mem_mem_2_reg <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_rd        <= '0;
            wb_reg_write  <= 1'b0;
            wb_mem_2_reg  <= 1'b0;
            wb_rd         <= '0;
            cnt           <= '0;
        end else begin
            if (!id_ex_hold) begin
                if (id_ex_bubble) begin
                    ex_alu_op    <= '0;
                    ex_alu_src   <= 1'b0;
                    ex_branch    <= 1'b0;
                    ex_jump      <= 1'b0;
                    ex_mem_read  <= 1'b0;
                    ex_mult      <= 1'b0;
                    ex_rd        <= '0;
                    ex_mem_write <= 1'b0;
                    ex_mem_2_reg <= 1'b0;
                    ex_reg_write <= 1'b0;
                end else begin
                    ex_alu_op    <= id_alu_op;
                    ex_alu_src   <= id_alu_src;
                    ex_branch    <= id_branch;
                    ex_jump      <= id_jump;
                    ex_mem_read  <= id_mem_read;
                    ex_mult      <= id_mult;
                    ex_rd        <= id_rd;
                    ex_mem_write <= id_mem_write;
                    ex_mem_2_reg <= id_mem_2_reg;
                    ex_reg_write <= id_reg_write;
                end
            end

            if (ex_mem_bubble) begin
                mem_mem_read  <= 1'b0;
                mem_mem_write <= 1'b0;
                mem_mem_2_reg <= 1'b0;
                mem_reg_write <= 1'b0;
                mem_rd        <= '0;
            end else begin
                mem_mem_read  <= ex_mem_read;
                mem_mem_write <= ex_mem_write;
                mem_mem_2_reg <= ex_mem_2_reg;
                mem_reg_write <= ex_reg_write;
                mem_rd        <= ex_rd;
            end

            wb_reg_write <= mem_reg_write;
            wb_mem_2_reg <= mem_mem_2_reg;
            wb_rd        <= mem_rd;

            // Counter returns to 0 on the cycle the multiply is released from EX
            cnt <= mult_busy ? cnt + 3'd1 : 3'd0;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write)
                stall_cycles <= stall_cycles + 32'd1;
            if (if_id_flush)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule
